// File: rtl/unidade_controle.sv
// Multi-cycle control FSM ahead of the ALU: fetch, decode, execute, memory, writeback.
// Optional build macro ZERO_EXT_LOGIC_EN makes ANDI/ORI zero-extend their immediate.
module unidade_controle #(
  parameter int PC_W = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instrucao,
  input  logic        mem_ready,
  input  logic        True,
  output logic [4:0]  ALU_op,
  output logic        Imm,
  output logic [31:0] estendido,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  pc_src,
  output logic        wb_src,
  output logic        illegal,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd1;
  localparam logic [5:0] OP_SUBI  = 6'd2;
  localparam logic [5:0] OP_ANDI  = 6'd3;
  localparam logic [5:0] OP_ORI   = 6'd4;
  localparam logic [5:0] OP_SLTI  = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd6;
  localparam logic [5:0] OP_SW    = 6'd7;
  localparam logic [5:0] OP_BEQ   = 6'd8;
  localparam logic [5:0] OP_BNE   = 6'd9;
  localparam logic [5:0] OP_BLT   = 6'd10;
  localparam logic [5:0] OP_J     = 6'd11;
  localparam logic [5:0] OP_HALT  = 6'd63;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [4:0] ALU_OP_RESET = 5'd13;

  // The jump target is 26 bits wide, so a narrower PC cannot hold it.
  if (PC_W < 26) begin : g_pc_w_check
    $error("unidade_controle: PC_W must be at least 26");
  end

  state_t      state_q, state_d;
  logic [31:0] instr_q;
  logic        boot_q;
  logic [4:0]  alu_op_q;
  logic        imm_q;
  logic [31:0] ext_q;
  logic [4:0]  rs_q, rt_q, rd_q;

  logic [5:0]  op;
  logic [4:0]  funct;
  logic [15:0] imm16;
  logic [4:0]  dec_alu_op;
  logic        dec_imm;
  logic        dec_legal;
  logic        zero_ext;
  logic [31:0] dec_ext;
  logic        is_branch, is_j, is_lw, is_sw, is_halt;
  logic        hold_off;

  assign op    = instr_q[31:26];
  assign funct = instr_q[4:0];
  assign imm16 = instr_q[15:0];

  assign is_branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT);
  assign is_j      = (op == OP_J);
  assign is_lw     = (op == OP_LW);
  assign is_sw     = (op == OP_SW);
  assign is_halt   = (op == OP_HALT);

`ifdef ZERO_EXT_LOGIC_EN
  assign zero_ext = (op == OP_ANDI) || (op == OP_ORI);
`else
  assign zero_ext = 1'b0;
`endif

  assign dec_ext = zero_ext ? {16'b0, imm16} : {{16{imm16[15]}}, imm16};

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    dec_alu_op = ALU_OP_RESET;
    dec_imm    = 1'b0;
    dec_legal  = 1'b1;
    unique case (op)
      OP_RTYPE: begin
        dec_alu_op = funct;
        dec_legal  = (funct <= 5'd13);
      end
      OP_ADDI:        begin dec_alu_op = 5'd0; dec_imm = 1'b1; end
      OP_SUBI:        begin dec_alu_op = 5'd1; dec_imm = 1'b1; end
      OP_ANDI:        begin dec_alu_op = 5'd4; dec_imm = 1'b1; end
      OP_ORI:         begin dec_alu_op = 5'd5; dec_imm = 1'b1; end
      OP_SLTI:        begin dec_alu_op = 5'd8; dec_imm = 1'b1; end
      OP_LW, OP_SW:   begin dec_alu_op = 5'd0; dec_imm = 1'b1; end
      OP_BEQ:         dec_alu_op = 5'd7;
      OP_BNE:         dec_alu_op = 5'd9;
      OP_BLT:         dec_alu_op = 5'd8;
      OP_J, OP_HALT:  dec_alu_op = ALU_OP_RESET;
      default:        dec_legal  = 1'b0;
    endcase
  end

  // Strobes stay quiet during reset and the cycle right after it.
  assign hold_off = reset || boot_q;

  always_comb begin
    state_d   = state_q;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pc_src    = PC_SEQ;
    wb_src    = 1'b0;
    illegal   = 1'b0;
    if (!hold_off) begin
      unique case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          if (!dec_legal) begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end else if (is_halt) begin
            state_d = S_HALT;
          end else begin
            state_d = S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (is_branch) begin
            pc_write = True;
            pc_src   = PC_BRANCH;
            state_d  = S_FETCH;
          end else if (is_j) begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
            state_d  = S_FETCH;
          end else if (is_lw || is_sw) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          mem_read  = is_lw;
          mem_write = is_sw;
          if (mem_ready) state_d = is_lw ? S_WB : S_FETCH;
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_src    = is_lw;
          state_d   = S_FETCH;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_FETCH;
      boot_q   <= 1'b1;
      instr_q  <= '0;
      alu_op_q <= ALU_OP_RESET;
      imm_q    <= 1'b0;
      ext_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= 1'b0;
      if (ir_write) instr_q <= instrucao;
      if (state_q == S_DECODE && dec_legal) begin
        alu_op_q <= dec_alu_op;
        imm_q    <= dec_imm;
        ext_q    <= dec_ext;
        rs_q     <= instr_q[25:21];
        rt_q     <= instr_q[20:16];
        rd_q     <= instr_q[15:11];
      end
    end
  end

  assign ALU_op    = alu_op_q;
  assign Imm       = imm_q;
  assign estendido = ext_q;
  assign rs        = rs_q;
  assign rt        = rt_q;
  assign rd        = rd_q;
  assign halted    = (state_q == S_HALT);

endmodule
